// File: rtl/pio_ball_detect.sv
// pio_ball_detect: synchronised, debounced ball-sensor input port with edge capture and maskable irq
module pio_ball_detect #(
    parameter logic [15:0] DEBOUNCE_DEFAULT = 16'd50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    input  logic        in_port,
    output logic [15:0] readdata,
    output logic        irq
);
    logic        s1, s2, stable;
    logic [15:0] cnt, thr;
    logic [1:0]  mask, edge_cap;
    logic        wr, settle, rise, fall;

    assign wr     = chipselect & ~write_n;
    assign settle = (s2 != stable) && (cnt >= thr);
    assign rise   = settle & s2;
    assign fall   = settle & ~s2;
    assign irq    = |(edge_cap & mask);

    // two-flop synchroniser for the asynchronous sensor line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    // debounce: stable follows s2 only after it has differed for more than thr compares
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            cnt    <= 16'd0;
        end else begin
            stable <= settle ? s2 : stable;
            cnt    <= (s2 == stable || settle) ? 16'd0 : cnt + {15'd0, cnt != 16'hFFFF};
        end
    end

    // bus-writable configuration and edge capture; a new edge beats a same-cycle W1C
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr      <= DEBOUNCE_DEFAULT;
            mask     <= 2'b00;
            edge_cap <= 2'b00;
        end else begin
            thr      <= (wr && address == 2'd1) ? writedata : thr;
            mask     <= (wr && address == 2'd2) ? writedata[1:0] : mask;
            edge_cap <= (edge_cap & ~((wr && address == 2'd3) ? writedata[1:0] : 2'b00)) | {fall, rise};
        end
    end

    // zero-latency read mux
    always_comb begin
        readdata = address == 2'd0 ? {15'd0, stable} :
                   address == 2'd1 ? thr :
                   address == 2'd2 ? {14'd0, mask} : {14'd0, edge_cap};
    end
endmodule

// File: doc/pio_ball_detect.md
# pio_ball_detect

Avalon-MM slave input port that samples the asynchronous infrared ball-sensor line. It synchronises and debounces the line, captures rising and falling edges, and raises a maskable interrupt to the Nios II core. The block sits on the same system bus as the kicker output ports and supplies the ball-presence input to the shoot firmware.

## Interface
Parameters:
- DEBOUNCE_DEFAULT, 16'd50: reset value of the debounce threshold register, in clk cycles.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- in_port  in  1  raw ball-sensor line, asynchronous to clk.
- readdata  out  16  read data; combinational, zero wait states.
- irq  out  1  level interrupt, active high.

## Operation
Register map. Unused bits read 0.
- Address 0, DATA (RO): bit0 = debounced level `stable`.
- Address 1, THRESH (RW): 16-bit debounce threshold `thr`.
- Address 2, MASK (RW): bit0 enables rising-edge interrupt, bit1 enables falling-edge interrupt.
- Address 3, EDGE (R/W1C): bit0 = rising edge captured, bit1 = falling edge captured. Writing 1 to a bit clears it; writing 0 leaves it unchanged.

Write path:
- A write occurs when chipselect=1 and write_n=0, on the rising clk edge.
- Writes to address 0 are ignored.

Input path:
- Two-flop synchroniser: in_port -> s1 -> s2. Both flops reset to 0.

Debounce, using a 16-bit counter `cnt`, evaluated every cycle:
- If s2 == stable: cnt <= 0.
- Else if cnt >= thr: stable <= s2 and cnt <= 0. This is the "transition".
- Else: cnt <= cnt + 1. cnt saturates at 16'hFFFF and never wraps.
- A glitch that returns before the transition resets cnt, so it never reaches `stable`.
- A THRESH write takes effect on the next compare, including in the middle of a count. If the new thr is <= the current cnt, the transition happens on the next cycle.
- With thr=0, `stable` follows s2 one cycle after s2 differs.

Edge capture:
- A 0->1 transition sets EDGE[0]; a 1->0 transition sets EDGE[1]. The set happens on the same clock edge that updates `stable`.
- Set and W1C clear of the same bit in the same cycle: set wins, and the bit stays 1.
- irq = |(EDGE & MASK[1:0]). It is combinational from registers and is glitch-free.

Reset values:
- s1, s2, stable, cnt = 0.
- THRESH = DEBOUNCE_DEFAULT; MASK = 0; EDGE = 0; irq = 0.
- readdata = 0 for addresses 0, 2 and 3, and DEBOUNCE_DEFAULT for address 1.
- Asserting reset mid-count discards the count and any pending edge.

## Timing
- in_port changes and is set up before clk edge k. Then s2 changes after edge k+1, and `stable`, EDGE and irq update at edge k+2+thr.
- A pulse on s2 shorter than thr+1 cycles is rejected.
- readdata is valid in the same cycle as address and chipselect, with no read latency. Reads have no side effects.
- A register write is visible on readdata in the cycle after the write edge.
- irq deasserts in the cycle after a W1C write or a MASK write that removes the cause.

## Test plan
- Reset: hold reset_n=0 and toggle in_port. Required: readdata at address 1 = 50, irq=0, DATA=0. Release reset with in_port=0; DATA stays 0 and EDGE=0.
- Clean rise: THRESH=3, MASK=1, drive in_port 0->1 before edge k. Required: DATA=1, EDGE=2'b01 and irq=1 exactly at edge k+5, not before.
- Glitch reject: THRESH=3, in_port high for 3 cycles, then low. Required: DATA stays 0, EDGE stays 0, irq stays 0. Repeat with 4 cycles high: DATA becomes 1.
- W1C and mask: after a rise and a fall, EDGE=2'b11 and MASK=2'b10, so irq=1. Write 2'b10 to address 3: EDGE=2'b01 and irq=0 the next cycle. Write MASK=1: irq=1.
- Simultaneous set/clear: write 1 to EDGE[0] on the same edge a rising transition occurs. Required: EDGE[0]=1.
- Threshold change mid-count: THRESH=100; after in_port has been high 40 cycles, write THRESH=10. Required: DATA=1 on the cycle after the write. Also check thr=0: the transition occurs at edge k+2.
